// File: rtl/dmem_load_if.sv
// Load-unit bus bundle: pipeline request/response, BRAM read port and busy status.
// The slave modport is the load unit; the master modport is the pipeline + BRAM side.
interface dmem_load_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        bram_en;
    logic [31:0] bram_addr;
    logic [31:0] bram_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_addr, req_size, req_unsigned, bram_rdata,
        input  req_ready, bram_en, bram_addr, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_unsigned, bram_rdata,
        output req_ready, bram_en, bram_addr, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/dmem_load_unit.sv
// Byte/halfword/word load path from a 32-bit data BRAM with sign/zero extension.
// Define DMEM_LOAD_SPLIT_EN to execute misaligned loads as two consecutive word reads.
module dmem_load_unit #(
    parameter int ADDR_W   = 8,
    parameter int BRAM_LAT = 1
) (
    input logic        clk,
    input logic        rst,
    dmem_load_if.slave bus
);
`ifdef DMEM_LOAD_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif
    localparam logic [2:0] LAT_C = 3'(BRAM_LAT);

    typedef enum logic [2:0] {IDLE, RD0, RD1, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;
    logic              split_q, split_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       word0_q, word0_d;
    logic [31:0]       word1_c;

    logic              ready_c, misalign_c, req_err_c, req_split_c;
    logic              bram_en_c;
    logic [31:0]       bram_addr_c;
    logic [63:0]       pair_c;
    logic [31:0]       lane_c, data_c;
    logic              unused_addr_c;

`ifdef DMEM_LOAD_SPLIT_EN
    logic [31:0] word1_q, word1_d;
    assign word1_c = word1_q;
`else
    assign word1_c = 32'h0;
`endif

    assign unused_addr_c = ^bus.req_addr[31:ADDR_W+2];
    assign ready_c       = (state_q == IDLE) && !rst;

    always_comb begin
        case (bus.req_size)
            2'b01:   misalign_c = (bus.req_addr[1:0] == 2'd3);
            2'b10:   misalign_c = (bus.req_addr[1:0] != 2'd0);
            default: misalign_c = 1'b0;
        endcase
    end

    assign req_split_c = misalign_c && SPLIT_EN;
    assign req_err_c   = (bus.req_size == 2'b11) || (misalign_c && !SPLIT_EN);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        err_d       = err_q;
        split_d     = split_q;
        cnt_d       = cnt_q;
        word0_d     = word0_q;
`ifdef DMEM_LOAD_SPLIT_EN
        word1_d     = word1_q;
`endif
        bram_en_c   = 1'b0;
        bram_addr_c = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_c) begin
                    idx_d   = bus.req_addr[ADDR_W+1:2];
                    off_d   = bus.req_addr[1:0];
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    err_d   = req_err_c;
                    split_d = req_split_c;
                    // Counter reaches 0 on the cycle the last needed word is on bram_rdata.
                    cnt_d   = LAT_C + {2'b00, req_split_c};
                    state_d = req_err_c ? RESP : RD0;
                end
            end
            RD0: begin
                bram_en_c                = 1'b1;
                bram_addr_c[ADDR_W-1:0]  = idx_q;
                state_d                  = split_q ? RD1 : WAIT;
            end
            RD1: begin
                bram_en_c                = 1'b1;
                bram_addr_c[ADDR_W-1:0]  = idx_q + ADDR_W'(1);
                state_d                  = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // With short latency word0 can arrive while RD1 is still issuing.
        if (state_q == RD0 || state_q == RD1 || state_q == WAIT) begin
            if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
            if (cnt_q == {2'b00, split_q}) word0_d = bus.bram_rdata;
`ifdef DMEM_LOAD_SPLIT_EN
            if (split_q && cnt_q == 3'd0) word1_d = bus.bram_rdata;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            off_q   <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            cnt_q   <= 3'd0;
            word0_q <= 32'h0;
`ifdef DMEM_LOAD_SPLIT_EN
            word1_q <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            split_q <= split_d;
            cnt_q   <= cnt_d;
            word0_q <= word0_d;
`ifdef DMEM_LOAD_SPLIT_EN
            word1_q <= word1_d;
`endif
        end
    end

    // Little-endian lanes: shift the two-word window down by the byte offset.
    assign pair_c = {word1_c, word0_q};
    assign lane_c = 32'(pair_c >> {off_q, 3'b000});

    always_comb begin
        case (size_q)
            2'b00:   data_c = {{24{~uns_q & lane_c[7]}},  lane_c[7:0]};
            2'b01:   data_c = {{16{~uns_q & lane_c[15]}}, lane_c[15:0]};
            default: data_c = lane_c;
        endcase
    end

    assign bus.req_ready = ready_c;
    assign bus.busy      = (state_q != IDLE);
    assign bus.bram_en   = bram_en_c;
    assign bus.bram_addr = bram_addr_c;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) && err_q;
    assign bus.rsp_data  = ((state_q == RESP) && !err_q) ? data_c : 32'h0;
endmodule

// File: tb/tb_dmem_load_unit.sv
// Randomized bench for dmem_load_unit against a byte-addressed reference model.
// Honors DMEM_LOAD_SPLIT_EN in its expectations.
module tb_dmem_load_unit;
    localparam int ADDR_W   = 8;
    localparam int BRAM_LAT = 1;
    localparam int DEPTH    = 1 << ADDR_W;
`ifdef DMEM_LOAD_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_load_if bus_if ();

    dmem_load_unit #(.ADDR_W(ADDR_W), .BRAM_LAT(BRAM_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // BRAM model: read data appears BRAM_LAT cycles after bram_en, garbage otherwise.
    logic [31:0] mem    [DEPTH];
    logic [31:0] pipe_d [BRAM_LAT];
    logic        pipe_v [BRAM_LAT];
    always @(posedge clk) begin
        pipe_v[0] <= bus_if.bram_en;
        pipe_d[0] <= mem[bus_if.bram_addr[ADDR_W-1:0]];
        for (int i = 1; i < BRAM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign bus_if.bram_rdata = pipe_v[BRAM_LAT-1] ? pipe_d[BRAM_LAT-1] : 32'hBAD0_BAD0;

    int n_vectors     = 0;
    int n_miscompares = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[(a >> 2) % DEPTH];
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic void ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                                     output logic [31:0] d, output logic e,
                                     output int lat, output int nrd);
        int nb;
        bit crosses;
        logic [31:0] v;
        nb      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        crosses = (int'(a[1:0]) + nb) > 4;
        d = 32'h0; e = 1'b1; lat = 1; nrd = 0;
        if (sz == 2'b11 || (crosses && !SPLIT)) return;
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(byte_at(a + 32'(i))) << (8 * i));
        if (nb < 4 && !u && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
        d   = v;
        e   = 1'b0;
        lat = crosses ? 3 + BRAM_LAT : 2 + BRAM_LAT;
        nrd = crosses ? 2 : 1;
    endfunction

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                           input bit hold, output logic [31:0] got);
        logic [31:0] exp_d, rsp_d, addr0, addr1;
        logic        exp_e, rsp_e;
        int          exp_lat, exp_nrd, lat, pulses, nrd, rd_cyc0, rd_cyc1;
        ref_load(a, sz, u, exp_d, exp_e, exp_lat, exp_nrd);
        lat = 0; pulses = 0; nrd = 0; rd_cyc0 = 0; rd_cyc1 = 0;
        rsp_d = 32'h0; rsp_e = 1'b0; addr0 = 32'h0; addr1 = 32'h0;
        @(negedge clk);
        check_value("ready_idle", 32'(bus_if.req_ready), 32'd1);
        bus_if.req_addr     = a;
        bus_if.req_size     = sz;
        bus_if.req_unsigned = u;
        bus_if.req_valid    = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus_if.bram_en) begin
                if (nrd == 0) begin addr0 = bus_if.bram_addr; rd_cyc0 = k; end
                else          begin addr1 = bus_if.bram_addr; rd_cyc1 = k; end
                nrd++;
            end
            if (bus_if.rsp_valid) begin
                pulses++;
                if (pulses == 1) begin
                    lat   = k;
                    rsp_d = bus_if.rsp_data;
                    rsp_e = bus_if.rsp_err;
                end
            end
            if (!hold || pulses > 0) bus_if.req_valid = 1'b0;
        end
        bus_if.req_valid = 1'b0;
        check_value("latency", 32'(lat), 32'(exp_lat));
        check_value("rsp_pulses", 32'(pulses), 32'd1);
        check_value("rsp_data", rsp_d, exp_d);
        check_value("rsp_err", 32'(rsp_e), 32'(exp_e));
        check_value("bram_reads", 32'(nrd), 32'(exp_nrd));
        if (exp_nrd >= 1) check_value("bram_addr0", addr0, (a >> 2) % DEPTH);
        if (exp_nrd == 2) begin
            check_value("bram_addr1", addr1, ((a >> 2) + 32'd1) % DEPTH);
            check_value("bram_back2back", 32'(rd_cyc1), 32'(rd_cyc0 + 1));
        end
        $display("load addr=%08h size=%0d uns=%0d hold=%0d -> data=%08h err=%0d lat=%0d reads=%0d",
                 a, sz, u, hold, rsp_d, rsp_e, lat, nrd);
        got = rsp_d;
    endtask

    task automatic reset_mid_read();
        int stray;
        stray = 0;
        @(negedge clk);
        bus_if.req_addr     = 32'h0;
        bus_if.req_size     = 2'b10;
        bus_if.req_unsigned = 1'b0;
        bus_if.req_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        check_value("rd0_bram_en", 32'(bus_if.bram_en), 32'd1);
        rst = 1'b1;
        #1;
        check_value("rst_bram_en", 32'(bus_if.bram_en), 32'd0);
        check_value("rst_busy", 32'(bus_if.busy), 32'd0);
        check_value("rst_ready", 32'(bus_if.req_ready), 32'd0);
        check_value("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check_value("rst_rsp_data", bus_if.rsp_data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus_if.rsp_valid) stray++;
        end
        check_value("no_rsp_after_rst", 32'(stray), 32'd0);
        $display("reset during RD0 -> stray responses=%0d", stray);
    endtask

    logic [31:0] d;

    initial begin
        rst                 = 1'b1;
        bus_if.req_valid    = 1'b0;
        bus_if.req_addr     = 32'h0;
        bus_if.req_size     = 2'b00;
        bus_if.req_unsigned = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0]       = 32'h80FF7F01;
        mem[1]       = 32'h55AA1234;
        mem[DEPTH-1] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        check_value("reset_ready", 32'(bus_if.req_ready), 32'd0);
        check_value("reset_busy", 32'(bus_if.busy), 32'd0);
        check_value("reset_bram_en", 32'(bus_if.bram_en), 32'd0);
        check_value("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        rst = 1'b0;

        do_load(32'h1, 2'b00, 1'b0, 1'b0, d); check_value("lb_1",   d, 32'h0000007F);
        do_load(32'h2, 2'b00, 1'b0, 1'b0, d); check_value("lb_2",   d, 32'hFFFFFFFF);
        do_load(32'h2, 2'b00, 1'b1, 1'b0, d); check_value("lbu_2",  d, 32'h000000FF);
        do_load(32'h2, 2'b01, 1'b0, 1'b0, d); check_value("lh_2",   d, 32'hFFFF80FF);
        do_load(32'h2, 2'b01, 1'b1, 1'b0, d); check_value("lhu_2",  d, 32'h000080FF);
        do_load(32'h0, 2'b10, 1'b0, 1'b0, d); check_value("lw_0",   d, 32'h80FF7F01);
        do_load(32'h2, 2'b10, 1'b0, 1'b0, d); check_value("lw_2",   d, SPLIT ? 32'h123480FF : 32'h0);
        do_load(32'h3FF, 2'b01, 1'b0, 1'b0, d); check_value("lh_wrap", d, SPLIT ? 32'h000001DE : 32'h0);
        do_load(32'h4, 2'b11, 1'b0, 1'b0, d); check_value("reserved", d, 32'h0);
        do_load(32'h0, 2'b10, 1'b0, 1'b1, d); check_value("lw_hold", d, 32'h80FF7F01);

        reset_mid_read();
        do_load(32'h0, 2'b10, 1'b0, 1'b0, d); check_value("lw_after_rst", d, 32'h80FF7F01);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, DEPTH-1)] = $urandom;
            do_load($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)), d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
